spi_flash_responder: RTL and testbench

- SPI mode-0 target that answers the flash command subset our bootloader's SPI master issues. It is the other end of the master link, which drives spi_sck, spi_so and spi_ss and samples spi_si.
- Serves JEDEC ID, status and sequential read from a byte-wide memory read port, and flags wake-up.
- Used as a board-level flash stand-in in system sims and in the loopback test build.
- Oversampled: all SPI pins are synchronised into clk. No logic is clocked by SCK.

---
 rtl/spi_flash_responder_pkg.sv | 26 ++
 rtl/spi_pin_sync.sv | 53 +++++
 rtl/spi_flash_responder.sv | 215 +++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_responder_pkg.sv
// Shared definitions for the SPI flash responder: the opcodes it answers,
// the FSM state encoding and the filler byte used after the JEDEC ID.
package spi_flash_responder_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] CMD_JEDEC = 8'h9F;
    localparam logic [7:0] CMD_WAKE  = 8'hAB;
    localparam logic [7:0] FILL_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_ID,
        ST_STAT,
        ST_DATA,
        ST_IGNORE
    } state_e;

    // States in which the responder owns the spi_so pad.
    function automatic logic drives_so(input state_e s);
        return s inside {ST_ID, ST_STAT, ST_DATA};
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the raw SPI pins into the clk domain and derives SCK edges and the
// start-of-transfer event. Edges are suppressed while chip select is high.
module spi_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic sck_i,
    input  logic ss_i,
    input  logic si_i,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic ss_active_o,
    output logic ss_start_o,
    output logic si_bit_o
);

    logic [1:0] sck_sync_q;
    logic       sck_dly_q;
    logic [1:0] ss_sync_q;
    logic [1:0] si_sync_q;
    // Marks the synchronisers as carrying real pin values (not reset values).
    logic [1:0] settle_q;
    // Set only once ss has genuinely been observed high on the pin, so a
    // transfer already running when reset releases is not picked up mid-way.
    logic       ss_high_q;

    // Two-flop synchronisers, SCK delay flop and settle tracking.
    always_ff @(posedge clk) begin
        // NOTE: flops are written with non-blocking assignments so every
        // stage samples the value from before this edge.
        if (rst) begin
            sck_sync_q <= 2'b00;
            sck_dly_q  <= 1'b0;
            ss_sync_q  <= 2'b11;
            si_sync_q  <= 2'b00;
            settle_q   <= 2'b00;
            ss_high_q  <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[0], sck_i};
            sck_dly_q  <= sck_sync_q[1];
            ss_sync_q  <= {ss_sync_q[0], ss_i};
            si_sync_q  <= {si_sync_q[0], si_i};
            settle_q   <= {settle_q[0], 1'b1};
            ss_high_q  <= ss_sync_q[1] & settle_q[1];
        end
    end

    assign sck_rise_o  =  sck_sync_q[1] & ~sck_dly_q & ~ss_sync_q[1];
    assign sck_fall_o  = ~sck_sync_q[1] &  sck_dly_q & ~ss_sync_q[1];
    assign ss_active_o = ~ss_sync_q[1];
    assign ss_start_o  = ~ss_sync_q[1] & ss_high_q;
    assign si_bit_o    =  si_sync_q[1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash stand-in: answers JEDEC ID, status and sequential read
// from a byte-wide memory port, and flags wake-up. Fully oversampled in clk.
module spi_flash_responder
    import spi_flash_responder_pkg::*;
#(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016,
    parameter logic [7:0]  STATUS   = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_ss,
    input  logic              spi_si,
    output logic              spi_so,
    output logic              spi_so_oe,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              cmd_valid,
    output logic [7:0]        cmd,
    output logic              wake
);

    logic sck_rise, sck_fall, ss_active, ss_start, si_bit;

    spi_pin_sync u_pin_sync (
        .clk        (clk),
        .rst        (rst),
        .sck_i      (spi_sck),
        .ss_i       (spi_ss),
        .si_i       (spi_si),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .ss_active_o(ss_active),
        .ss_start_o (ss_start),
        .si_bit_o   (si_bit)
    );

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_sr_q, rx_sr_d;
    logic [7:0]        tx_sr_q, tx_sr_d;
    logic              so_q, so_d;
    logic [15:0]       addr_hi_q, addr_hi_d;
    logic [1:0]        addr_cnt_q, addr_cnt_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic [7:0]        cmd_q, cmd_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              wake_q, wake_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              load_q, load_d;

    logic [7:0]  rx_byte;
    logic        byte_done;
    logic [23:0] full_addr;

    assign rx_byte   = {rx_sr_q[6:0], si_bit};
    assign byte_done = sck_rise & (bit_cnt_q == 3'd7);
    assign full_addr = {addr_hi_q, rx_byte};

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            so_q        <= 1'b0;
            addr_hi_q   <= '0;
            addr_cnt_q  <= '0;
            id_idx_q    <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            wake_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            so_q        <= so_d;
            addr_hi_q   <= addr_hi_d;
            addr_cnt_q  <= addr_cnt_d;
            id_idx_q    <= id_idx_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            wake_q      <= wake_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            load_q      <= load_d;
        end
    end

    // Bit shifting, command decode and response sequencing.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        so_d        = so_q;
        addr_hi_d   = addr_hi_q;
        addr_cnt_d  = addr_cnt_q;
        id_idx_d    = id_idx_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        wake_d      = 1'b0;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        load_d      = mem_rd_q;

        if (sck_rise) begin
            rx_sr_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (sck_fall) begin
            so_d    = tx_sr_q[7];
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
        end
        // Memory data arrives one clk after the strobe; it wins over a shift.
        if (load_q) begin
            tx_sr_d = mem_data;
        end

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                tx_sr_d   = '0;
                so_d      = 1'b0;
                if (ss_start) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (byte_done) begin
                    cmd_d       = rx_byte;
                    cmd_valid_d = 1'b1;
                    case (rx_byte)
                        CMD_JEDEC: begin
                            state_d  = ST_ID;
                            tx_sr_d  = JEDEC_ID[23:16];
                            id_idx_d = '0;
                        end
                        CMD_RDSR: begin
                            state_d = ST_STAT;
                            tx_sr_d = STATUS;
                        end
                        CMD_READ: begin
                            state_d    = ST_ADDR;
                            addr_cnt_d = '0;
                        end
                        CMD_WAKE: begin
                            wake_d  = 1'b1;
                            state_d = ST_IGNORE;
                        end
                        default: state_d = ST_IGNORE;
                    endcase
                end
            end
            ST_ADDR: begin
                if (byte_done) begin
                    addr_hi_d  = {addr_hi_q[7:0], rx_byte};
                    addr_cnt_d = addr_cnt_q + 2'd1;
                    if (addr_cnt_q == 2'd2) begin
                        mem_addr_d = full_addr[ADDR_W-1:0];
                        mem_rd_d   = 1'b1;
                        state_d    = ST_DATA;
                    end
                end
            end
            ST_ID: begin
                if (byte_done) begin
                    case (id_idx_q)
                        2'd0:    tx_sr_d = JEDEC_ID[15:8];
                        2'd1:    tx_sr_d = JEDEC_ID[7:0];
                        default: tx_sr_d = FILL_BYTE;
                    endcase
                    if (id_idx_q != 2'd2) id_idx_d = id_idx_q + 2'd1;
                end
            end
            ST_STAT: begin
                if (byte_done) tx_sr_d = STATUS;
            end
            ST_DATA: begin
                // Prefetch the next byte; the address wraps naturally.
                if (byte_done) begin
                    mem_addr_d = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    mem_rd_d   = 1'b1;
                end
            end
            ST_IGNORE: begin
            end
            default: state_d = ST_IDLE;
        endcase

        // Deselect aborts everything; edges are already masked while ss is
        // high, so a byte landing in the same clk never completes.
        if (state_q != ST_IDLE && !ss_active) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
        end
    end

    assign spi_so_oe = drives_so(state_q);
    assign spi_so    = spi_so_oe & so_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign wake      = wake_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench acting as the SPI master at clk/8, with a behavioural flash model.
// A 24-bit and an 8-bit address instance share the SPI pins.
module tb_spi_flash_responder;

    localparam int          HALF   = 4;
    localparam logic [23:0] ID     = 24'hEF4016;
    localparam logic [7:0]  STAT_B = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_sck = 1'b0;
    logic spi_ss  = 1'b1;
    logic spi_si  = 1'b0;

    logic        so24, oe24, rd24, cv24, wake24;
    logic [23:0] addr24;
    logic [7:0]  data24 = 8'h00, cmd24;
    logic        so8, oe8, rd8, cv8, wake8;
    logic [7:0]  addr8;
    logic [7:0]  data8 = 8'h00, cmd8;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]  mosi_q[$];
    logic [7:0]  miso24_q[$];
    logic [7:0]  miso8_q[$];
    logic [23:0] rd24_q[$];
    logic [7:0]  rd8_q[$];
    int          cv_n = 0;
    logic [7:0]  cv_last = 8'h00;
    int          wake_n = 0;
    bit          oe_seen = 1'b0;

    always #5 clk = ~clk;

    spi_flash_responder #(.ADDR_W(24)) dut (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_si(spi_si),
        .spi_so(so24), .spi_so_oe(oe24), .mem_rd(rd24), .mem_addr(addr24),
        .mem_data(data24), .cmd_valid(cv24), .cmd(cmd24), .wake(wake24)
    );

    spi_flash_responder #(.ADDR_W(8)) dut8 (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_si(spi_si),
        .spi_so(so8), .spi_so_oe(oe8), .mem_rd(rd8), .mem_addr(addr8),
        .mem_data(data8), .cmd_valid(cv8), .cmd(cmd8), .wake(wake8)
    );

    // Memory: byte at an address is its low 8 bits, one clk after the strobe.
    always @(posedge clk) begin
        if (rd24) data24 <= addr24[7:0];
        if (rd8)  data8  <= addr8;
    end

    // Event monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rd24) rd24_q.push_back(addr24);
        if (rd8)  rd8_q.push_back(addr8);
        if (cv24) begin
            cv_n    = cv_n + 1;
            cv_last = cmd24;
        end
        if (wake24) wake_n = wake_n + 1;
        if (oe24) oe_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: k-th response byte after the command/address phase.
    function automatic logic [7:0] model_resp(input logic [7:0] c, input logic [23:0] a, input int k);
        logic [23:0] s;
        case (c)
            8'h9F: begin
                if (k < 3) begin
                    s = ID >> (8 * (2 - k));
                    return s[7:0];
                end
                return 8'hFF;
            end
            8'h05:   return STAT_B;
            8'h03: begin
                s = a + 24'(k);
                return s[7:0];
            end
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [23:0] model_addr(input int aw, input logic [23:0] a, input int k);
        logic [23:0] s;
        s = a + 24'(k);
        if (aw < 24) s = s & ((24'd1 << aw) - 24'd1);
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rd24_q.delete();
        rd8_q.delete();
        miso24_q.delete();
        miso8_q.delete();
        cv_n    = 0;
        wake_n  = 0;
        oe_seen = 1'b0;
    endtask

    task automatic ss_begin();
        spi_ss = 1'b0;
        tick(2 * HALF);
    endtask

    task automatic ss_end();
        spi_ss = 1'b1;
        tick(3 * HALF);
    endtask

    // Master shifting; with coincide the last rise and ss release are driven
    // together, so the responder must drop that final byte.
    task automatic shift_bits(input int nbits, input bit coincide);
        logic [7:0] b24, b8, ob;
        b24 = '0;
        b8  = '0;
        for (int i = 0; i < nbits; i++) begin
            ob = (i / 8 < mosi_q.size()) ? mosi_q[i / 8] : 8'h00;
            spi_si = ob[7 - (i % 8)];
            tick(HALF);
            b24 = {b24[6:0], so24};
            b8  = {b8[6:0], so8};
            spi_sck = 1'b1;
            if (coincide && i == nbits - 1) spi_ss = 1'b1;
            if (i % 8 == 7) begin
                miso24_q.push_back(b24);
                miso8_q.push_back(b8);
            end
            tick(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic xfer(input int nbits, input bit coincide);
        clear_mon();
        ss_begin();
        shift_bits(nbits, coincide);
        ss_end();
    endtask

    task automatic do_read(input string tag, input logic [23:0] a, input int n);
        mosi_q.delete();
        mosi_q.push_back(8'h03);
        mosi_q.push_back(a[23:16]);
        mosi_q.push_back(a[15:8]);
        mosi_q.push_back(a[7:0]);
        for (int k = 0; k < n; k++) mosi_q.push_back(8'($urandom));
        xfer(8 * (4 + n), 1'b1);
        check({tag, "_cmd_n"}, cv_n, 1);
        check({tag, "_cmd"}, cv_last, 8'h03);
        check({tag, "_oe"}, oe_seen, 1);
        check({tag, "_nrd24"}, rd24_q.size(), n);
        check({tag, "_nrd8"}, rd8_q.size(), n);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_byte%0d", tag, k), miso24_q[4 + k], model_resp(8'h03, a, k));
            check($sformatf("%s_byte8_%0d", tag, k), miso8_q[4 + k], model_resp(8'h03, a, k));
            check($sformatf("%s_addr24_%0d", tag, k),
                  (k < rd24_q.size()) ? 32'(rd24_q[k]) : 32'hxxxxxxxx, model_addr(24, a, k));
            check($sformatf("%s_addr8_%0d", tag, k),
                  (k < rd8_q.size()) ? 32'(rd8_q[k]) : 32'hxxxxxxxx, model_addr(8, a, k));
        end
    endtask

    task automatic do_simple(input string tag, input logic [7:0] c, input int n);
        mosi_q.delete();
        mosi_q.push_back(c);
        for (int k = 0; k < n; k++) mosi_q.push_back(8'($urandom));
        xfer(8 * (1 + n), 1'b0);
        check({tag, "_cmd_n"}, cv_n, 1);
        check({tag, "_cmd"}, cv_last, c);
        check({tag, "_wake"}, wake_n, (c == 8'hAB) ? 1 : 0);
        check({tag, "_nrd"}, rd24_q.size(), 0);
        check({tag, "_oe"}, oe_seen, (c == 8'h9F || c == 8'h05) ? 1 : 0);
        for (int k = 0; k < n; k++)
            check($sformatf("%s_byte%0d", tag, k), miso24_q[1 + k], model_resp(c, 24'h0, k));
    endtask

    initial begin
        logic [7:0]  op;
        logic [23:0] a;

        // Reset state
        tick(3);
        check("rst_so", so24, 0);
        check("rst_oe", oe24, 0);
        check("rst_rd", rd24, 0);
        check("rst_addr", addr24, 0);
        check("rst_cv", cv24, 0);
        check("rst_cmd", cmd24, 0);
        check("rst_wake", wake24, 0);
        rst = 1'b0;
        tick(6);

        // Directed functions
        do_simple("jedec", 8'h9F, 4);
        do_read("read", 24'h0001FE, 3);
        do_read("wrap", 24'h0000FF, 2);
        do_simple("stat", 8'h05, 2);
        do_simple("wake", 8'hAB, 0);
        do_simple("unk", 8'h42, 1);

        // Abort mid address: 5 bits into the second address byte
        mosi_q.delete();
        mosi_q.push_back(8'h03);
        mosi_q.push_back(8'h12);
        mosi_q.push_back(8'hFF);
        xfer(21, 1'b0);
        check("abort_nrd", rd24_q.size(), 0);
        check("abort_cmd_n", cv_n, 1);
        do_simple("abort_id", 8'h9F, 3);

        // Reset in the middle of a read data phase
        clear_mon();
        mosi_q.delete();
        mosi_q.push_back(8'h03);
        mosi_q.push_back(8'h00);
        mosi_q.push_back(8'h00);
        mosi_q.push_back(8'h10);
        ss_begin();
        shift_bits(40, 1'b0);
        check("mid_oe", oe24, 1);
        rst = 1'b1;
        tick(1);
        check("mrst_so", so24, 0);
        check("mrst_oe", oe24, 0);
        check("mrst_rd", rd24, 0);
        check("mrst_addr", addr24, 0);
        check("mrst_cv", cv24, 0);
        check("mrst_cmd", cmd24, 0);
        check("mrst_wake", wake24, 0);
        rst = 1'b0;
        clear_mon();
        mosi_q.delete();
        shift_bits(16, 1'b0);
        check("mrst_ignored_cv", cv_n, 0);
        check("mrst_ignored_oe", oe_seen, 0);
        check("mrst_ignored_rd", rd24_q.size(), 0);
        ss_end();
        do_simple("post_rst_id", 8'h9F, 3);

        // Randomized transactions
        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = 24'($urandom);
                    if ($urandom_range(0, 1) == 1) a[7:0] = 8'hFE;
                    do_read($sformatf("r%0d_read", t), a, $urandom_range(1, 4));
                end
                1: do_simple($sformatf("r%0d_jedec", t), 8'h9F, $urandom_range(1, 5));
                2: do_simple($sformatf("r%0d_stat", t), 8'h05, $urandom_range(1, 3));
                default: begin
                    do op = 8'($urandom);
                    while (op inside {8'h03, 8'h05, 8'h9F, 8'hAB});
                    do_simple($sformatf("r%0d_op%02h", t, op), op, 1);
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
